keypad_scan_ctrl: RTL and testbench

Scan controller for the 4x4 matrix keyboard. It sequences row drive, samples the column lines through a synchronizer, and debounces whole scan frames. It rejects multi-key (ghosting) frames and turns clean key presses into events. Events are buffered in a small FIFO with a valid/ready handshake toward the consuming logic (display/UART path).

---
 rtl/keypad_scan_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: row sequencing, column synchronizer, frame debounce and event FIFO.
// Optional release events are enabled by defining KEYPAD_RELEASE_EVT_EN.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [3:0] key_code,
  output logic [7:0] key_raw,
`ifdef KEYPAD_RELEASE_EVT_EN
  output logic       key_release,
`endif
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef KEYPAD_RELEASE_EVT_EN
  localparam int EW = 13;
`else
  localparam int EW = 12;
`endif

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);
  localparam logic [SW-1:0] STABLE_PRE = SW'(DEBOUNCE_SCANS - 1);
  localparam logic [AW:0]   DEPTH_CNT  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [15:0]   snapshot_q, snapshot_d;
  logic          eval_q, eval_d;
  logic [15:0]   prev_snap_q, prev_snap_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [15:0]   deb_map_q, deb_map_d;
  logic [EW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [EW-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          push;
  logic [EW-1:0] push_entry;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic [EW-1:0] head;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    return cnt;
  endfunction

  function automatic logic [3:0] lowest_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [7:0] raw_of(input logic [3:0] code);
    return {4'b0001 << code[3:2], 4'b0001 << code[1:0]};
  endfunction

  // Column lines are asynchronous; only sync2_q is ever used downstream.
  always_comb begin
    sync1_d = col;
    sync2_d = sync1_q;
  end

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    row_idx_d  = row_idx_q;
    snapshot_d = snapshot_q;
    eval_d     = 1'b0;
    if (!scan_en) begin
      state_d    = ST_IDLE;
      dwell_d    = '0;
      row_idx_d  = '0;
      snapshot_d = '0;
    end else if (state_q == ST_IDLE) begin
      state_d   = ST_SCAN;
      dwell_d   = '0;
      row_idx_d = '0;
    end else if (dwell_q == DWELL_LAST) begin
      dwell_d                            = '0;
      snapshot_d[{row_idx_q, 2'b00} +: 4] = ~sync2_q;
      row_idx_d                          = row_idx_q + 2'd1;
      eval_d                             = (row_idx_q == 2'd3);
    end else begin
      dwell_d = dwell_q + DW'(1);
    end
    row_d = (state_d == ST_SCAN) ? ~(4'b0001 << row_idx_d) : 4'b1111;
  end

  // A frame is accepted only on the transition into the stable count, so a held key loads once.
  always_comb begin
    prev_snap_d = prev_snap_q;
    stable_d    = stable_q;
    deb_map_d   = deb_map_q;
    push        = 1'b0;
    push_entry  = '0;
    if (eval_q) begin
      prev_snap_d = snapshot_q;
      if (snapshot_q == prev_snap_q) begin
        if (stable_q != STABLE_MAX) begin
          stable_d = stable_q + SW'(1);
        end
        if (stable_q == STABLE_PRE) begin
          deb_map_d = snapshot_q;
          if ((popcount16(snapshot_q) == 5'd1) && ((snapshot_q & ~deb_map_q) != 16'h0000)) begin
            push                 = 1'b1;
            push_entry[11:0]     = {lowest_index(snapshot_q), raw_of(lowest_index(snapshot_q))};
          end
`ifdef KEYPAD_RELEASE_EVT_EN
          else if ((snapshot_q == 16'h0000) && (popcount16(deb_map_q) == 5'd1)) begin
            push       = 1'b1;
            push_entry = {1'b1, lowest_index(deb_map_q), raw_of(lowest_index(deb_map_q))};
          end
`endif
        end
      end else begin
        stable_d = '0;
      end
    end
  end

  assign key_valid = (count_q != '0);
  assign fifo_full = (count_q == DEPTH_CNT);
  assign pop       = key_valid & key_ready;
  assign push_ok   = push & (~fifo_full | pop);

  // No bypass: an empty FIFO cannot pop, so a push into it shows up one cycle later.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (push_ok) begin
      fifo_mem_d[wr_ptr_q] = push_entry;
    end
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (push & fifo_full & ~pop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= 4'b1111;
      dwell_q     <= '0;
      row_idx_q   <= '0;
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      snapshot_q  <= '0;
      eval_q      <= 1'b0;
      prev_snap_q <= '0;
      stable_q    <= '0;
      deb_map_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      row_idx_q   <= row_idx_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      snapshot_q  <= snapshot_d;
      eval_q      <= eval_d;
      prev_snap_q <= prev_snap_d;
      stable_q    <= stable_d;
      deb_map_q   <= deb_map_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign head     = fifo_mem_q[rd_ptr_q];
  assign row      = row_q;
  assign key_raw  = head[7:0];
  assign key_code = head[11:8];
  assign overflow = overflow_q;
`ifdef KEYPAD_RELEASE_EVT_EN
  assign key_release = head[12];
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: keypad matrix model, vector table and event scoreboard.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scan_en;
  logic [3:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;
  logic [7:0] key_raw;
  logic       overflow;
  logic       clr_overflow;
`ifdef KEYPAD_RELEASE_EVT_EN
  logic       key_release;
`endif

  logic [15:0] keys;
  int          total = 0;
  int          bad   = 0;
  logic [3:0]  sb[$];

  typedef struct {
    logic [15:0] keys;
    int          hold;
    logic        expect_evt;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[6];

  keypad_scan_ctrl #(
    .SCAN_DIV(8),
    .DEBOUNCE_SCANS(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scan_en(scan_en),
    .col(col),
    .row(row),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_code(key_code),
    .key_raw(key_raw),
`ifdef KEYPAD_RELEASE_EVT_EN
    .key_release(key_release),
`endif
    .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row[r]) begin
          col[c] = 1'b0;
        end
      end
    end
  end

  function automatic logic [7:0] expRaw(input logic [3:0] code);
    logic [3:0] one;
    one = 4'b0001;
    return {one << code[3:2], one << code[1:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkEvent();
    logic [3:0] exp_code;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected_event actual=code %0d required=no event at %0t", key_code, $time);
    end else begin
      exp_code = sb.pop_front();
      checkOutput("evt_code", 32'(key_code), 32'(exp_code));
      checkOutput("evt_raw", 32'(key_raw), 32'(expRaw(exp_code)));
    end
  endtask

  // One clock: outputs checked at the falling edge, inputs changed just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst_n && key_valid && key_ready) begin
      checkEvent();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] k, input int frames);
    keys = k;
    repeat (frames * 32) tick();
  endtask

  initial begin
    logic [3:0] exp_row;
    logic [3:0] press_codes [5];
    int n;

    vecs[0] = '{keys: 16'h0040, hold: 5, expect_evt: 1'b1, code: 4'd6};
    vecs[1] = '{keys: 16'h0001, hold: 5, expect_evt: 1'b1, code: 4'd0};
    vecs[2] = '{keys: 16'h8000, hold: 5, expect_evt: 1'b1, code: 4'd15};
    vecs[3] = '{keys: 16'h0021, hold: 5, expect_evt: 1'b0, code: 4'd0};
    vecs[4] = '{keys: 16'h0200, hold: 5, expect_evt: 1'b1, code: 4'd9};
    vecs[5] = '{keys: 16'h1400, hold: 5, expect_evt: 1'b0, code: 4'd0};
    press_codes[0] = 4'd1;
    press_codes[1] = 4'd2;
    press_codes[2] = 4'd3;
    press_codes[3] = 4'd4;
    press_codes[4] = 4'd7;

    rst_n = 1'b0;
    scan_en = 1'b0;
    key_ready = 1'b0;
    clr_overflow = 1'b0;
    keys = '0;
    repeat (3) tick();
    checkOutput("rst_row", 32'(row), 32'h0000000f);
    checkOutput("rst_valid", 32'(key_valid), 32'h0);
    checkOutput("rst_code", 32'(key_code), 32'h0);
    checkOutput("rst_raw", 32'(key_raw), 32'h0);
    checkOutput("rst_overflow", 32'(overflow), 32'h0);

    rst_n = 1'b1;
    tick();
    checkOutput("idle_row", 32'(row), 32'h0000000f);

    // Row sequence: each row low for 8 cycles, starting the cycle after scan_en is sampled.
    scan_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      exp_row = ~(4'b0001 << ((i / 8) % 4));
      checkOutput("row_seq", 32'(row), 32'(exp_row));
      checkOutput("scan_quiet", 32'({key_valid, overflow}), 32'h0);
    end

    key_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].expect_evt) begin
        sb.push_back(vecs[v].code);
      end
      applyStimulus(vecs[v].keys, vecs[v].hold);
      applyStimulus(16'h0000, 4);
      checkOutput("vec_sb_empty", 32'(sb.size()), 32'h0);
    end

    // Key toggling every frame must not debounce; the hold afterwards yields one event.
    applyStimulus(16'h0040, 1);
    applyStimulus(16'h0000, 1);
    sb.push_back(4'd6);
    applyStimulus(16'h0040, 5);
    applyStimulus(16'h0000, 4);
    checkOutput("toggle_sb_empty", 32'(sb.size()), 32'h0);

    applyStimulus(16'h0021, 5);
    applyStimulus(16'h0020, 5);
    applyStimulus(16'h0000, 4);
    checkOutput("ghost_valid", 32'(key_valid), 32'h0);
    checkOutput("ghost_sb_empty", 32'(sb.size()), 32'h0);

    // Fill the FIFO with the consumer stalled; the fifth press is dropped.
    key_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        sb.push_back(press_codes[k]);
      end
      applyStimulus(16'h0001 << press_codes[k], 5);
      applyStimulus(16'h0000, 4);
      if (k == 3) begin
        checkOutput("full_no_overflow", 32'(overflow), 32'h0);
      end
    end
    checkOutput("ovf_valid", 32'(key_valid), 32'h1);
    checkOutput("ovf_head_code", 32'(key_code), 32'h1);
    checkOutput("ovf_head_raw", 32'(key_raw), 32'(expRaw(4'd1)));
    checkOutput("ovf_flag", 32'(overflow), 32'h1);
    key_ready = 1'b1;
    repeat (8) tick();
    checkOutput("drain_sb_empty", 32'(sb.size()), 32'h0);
    checkOutput("drain_valid", 32'(key_valid), 32'h0);
    checkOutput("ovf_sticky", 32'(overflow), 32'h1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    checkOutput("ovf_cleared", 32'(overflow), 32'h0);

    // Dropping scan_en mid-frame releases rows but keeps FIFO contents.
    key_ready = 1'b0;
    sb.push_back(4'd2);
    applyStimulus(16'h0004, 5);
    applyStimulus(16'h0000, 1);
    checkOutput("hold_valid", 32'(key_valid), 32'h1);
    n = 0;
    while (row != 4'b1011 && n < 64) begin
      tick();
      n++;
    end
    checkOutput("row_1011_seen", 32'(row), 32'hb);
    scan_en = 1'b0;
    tick();
    checkOutput("dis_row", 32'(row), 32'hf);
    checkOutput("dis_valid", 32'(key_valid), 32'h1);
    checkOutput("dis_code", 32'(key_code), 32'h2);
    repeat (3) tick();
    checkOutput("dis_row_hold", 32'(row), 32'hf);
    scan_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("reen_row0", 32'(row), 32'he);
    end
    tick();
    checkOutput("reen_row1", 32'(row), 32'hd);
    key_ready = 1'b1;
    repeat (4) tick();
    checkOutput("reen_sb_empty", 32'(sb.size()), 32'h0);

    // Reset with a pending event discards it.
    key_ready = 1'b0;
    applyStimulus(16'h0200, 5);
    applyStimulus(16'h0000, 2);
    checkOutput("pre_rst_valid", 32'(key_valid), 32'h1);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_valid", 32'(key_valid), 32'h0);
    checkOutput("mid_rst_code", 32'(key_code), 32'h0);
    checkOutput("mid_rst_row", 32'(row), 32'hf);
    rst_n = 1'b1;
    key_ready = 1'b1;
    repeat (40) tick();
    checkOutput("post_rst_valid", 32'(key_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
